// File: rtl/kbd_pkg.sv
// kbd_pkg: shared event-code constants and helpers for the keyboard/encoder front end.
package kbd_pkg;
    localparam int KBD_EVENT_WIDTH = 8;
    localparam logic [7:0] KBD_KEY_BASE = 8'h00;
    localparam logic [7:0] KBD_CW_BASE = 8'h40;
    localparam logic [7:0] KBD_CCW_BASE = 8'h48;
    localparam logic [7:0] KBD_JOY_BASE = 8'h60;
    localparam logic [15:0] KBD_CPLD_VERSION = 16'h0102;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_CW   = 2'd1,
        STEP_CCW  = 2'd2
    } step_t;

    // Quadrature {A,B} to position: 11->0, 01->1, 00->2, 10->3 (clockwise counts up)
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {~ab[0], ab[1] ^ ab[0]};
    endfunction
endpackage

// File: rtl/enc_quad_decoder.sv
// enc_quad_decoder: synchronizes and debounces one encoder's A/B lines and emits one-cycle detent step pulses.
module enc_quad_decoder
    import kbd_pkg::*;
#(
    parameter int DEB_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_a,
    input  logic line_b,
    output logic stepCw,
    output logic stepCcw
);
    logic [1:0] s1, s2, deb, deb_nxt, d;
    logic [1:0][3:0] cnt, cnt_nxt;
    logic signed [2:0] acc, acc_nxt;
    logic signed [3:0] sum;
    logic legal, home;
    step_t step;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_nxt[i] = (s2[i] == deb[i] || cnt[i] == 4'(DEB_LEN - 1)) ? 4'd0 : cnt[i] + 4'd1;
            deb_nxt[i] = (s2[i] != deb[i] && cnt[i] == 4'(DEB_LEN - 1)) ? s2[i] : deb[i];
        end
        d = gray_pos(deb_nxt) - gray_pos(deb);
        // d==2 means both bits flipped at once: illegal, so only odd deltas count
        legal = d[0];
        home = deb_nxt == 2'b11;
        sum = $signed({acc[2], acc}) + (d == 2'd1 ? 4'sd1 : -4'sd1);
        step = !(legal && home) ? STEP_NONE : sum == 4'sd4 ? STEP_CW : sum == -4'sd4 ? STEP_CCW : STEP_NONE;
        acc_nxt = !legal ? acc : home ? 3'sd0 : (sum > 4'sd3 || sum < -4'sd3) ? acc : sum[2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 2'b11;
            s2 <= 2'b11;
            deb <= 2'b11;
            cnt <= '0;
            acc <= 3'sd0;
            stepCw <= 1'b0;
            stepCcw <= 1'b0;
        end else begin
            s1 <= {line_a, line_b};
            s2 <= s1;
            deb <= deb_nxt;
            cnt <= cnt_nxt;
            acc <= acc_nxt;
            stepCw <= step == STEP_CW;
            stepCcw <= step == STEP_CCW;
        end
    end
endmodule

// File: rtl/encoder_event_gen.sv
// encoder_event_gen: buffers encoder steps per encoder and drains them round-robin as FIFO event codes.
module encoder_event_gen
    import kbd_pkg::*;
#(
    parameter int NUM_ENC = 4,
    parameter int DEB_LEN = 4,
    parameter int EVENT_WIDTH = KBD_EVENT_WIDTH,
    parameter logic [EVENT_WIDTH-1:0] CW_BASE = EVENT_WIDTH'(KBD_CW_BASE),
    parameter logic [EVENT_WIDTH-1:0] CCW_BASE = EVENT_WIDTH'(KBD_CCW_BASE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_ENC-1:0]     encLinesA,
    input  logic [NUM_ENC-1:0]     encLinesB,
    input  logic                   fifoFull,
    input  logic                   clrReq,
    output logic                   evReady,
    output logic [EVENT_WIDTH-1:0] evCode,
    output logic                   stepOvf
);
    localparam int PW = NUM_ENC > 1 ? $clog2(NUM_ENC) : 1;

    logic [NUM_ENC-1:0] step_cw, step_ccw;
    logic signed [3:0] pend [NUM_ENC];
    logic signed [3:0] pend_nxt [NUM_ENC];
    logic signed [4:0] base [NUM_ENC];
    logic signed [4:0] tot [NUM_ENC];
    logic [PW-1:0] ptr, ptr_nxt, k;
    logic found, issue, ovf;

    for (genvar g = 0; g < NUM_ENC; g++) begin : g_dec
        enc_quad_decoder #(.DEB_LEN(DEB_LEN)) u_dec (
            .clk    (clk),
            .rst_n  (rst_n),
            .line_a (encLinesA[g]),
            .line_b (encLinesB[g]),
            .stepCw (step_cw[g]),
            .stepCcw(step_ccw[g])
        );
    end

    always_comb begin
        found = 1'b0;
        k = ptr;
        for (int j = 0; j < NUM_ENC; j++) begin
            if (!found && pend[PW'((int'(ptr) + j) % NUM_ENC)] != 4'sd0) begin
                found = 1'b1;
                k = PW'((int'(ptr) + j) % NUM_ENC);
            end
        end
        issue = found && !fifoFull && !clrReq;
        ovf = 1'b0;
        // Issue and new step are netted together; only the step is dropped on saturation
        for (int i = 0; i < NUM_ENC; i++) begin
            base[i] = $signed({pend[i][3], pend[i]}) + ((issue && k == PW'(i)) ? (pend[i][3] ? 5'sd1 : -5'sd1) : 5'sd0);
            tot[i] = base[i] + (step_cw[i] ? 5'sd1 : step_ccw[i] ? -5'sd1 : 5'sd0);
            ovf = ovf | (tot[i] > 5'sd7 || tot[i] < -5'sd7);
            pend_nxt[i] = clrReq ? 4'sd0 : (tot[i] > 5'sd7 || tot[i] < -5'sd7) ? base[i][3:0] : tot[i][3:0];
        end
        ptr_nxt = issue ? PW'((int'(k) + 1) % NUM_ENC) : ptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENC; i++) pend[i] <= 4'sd0;
            ptr <= '0;
            evReady <= 1'b0;
            evCode <= '0;
            stepOvf <= 1'b0;
        end else begin
            pend <= pend_nxt;
            ptr <= ptr_nxt;
            evReady <= issue;
            stepOvf <= ovf && !clrReq;
            if (issue) evCode <= pend[k][3] ? CCW_BASE + EVENT_WIDTH'(k) : CW_BASE + EVENT_WIDTH'(k);
        end
    end
endmodule
